tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
- Receiver-side companion to the auto-reset counter: it watches a single-cycle tick stream (the counter's autoreset pulse) and recovers the interval between ticks.
- Reports each measured interval over a valid/ready handshake.
- Asserts locked once the interval has been stable for LOCK_COUNT consecutive measurements, for self-checking of the lab counter chain.

Parameters:
- WIDTH, 8: width of the interval counter and of the period output. Maximum measurable interval is 2^WIDTH-1.
- LOCK_COUNT, 3: number of consecutive identical measurements required for lock. Legal range 2..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count qualifier; only cycles with en=1 are counted.
- tick  input  1  single-cycle pulse to be measured.
- out_ready  input  1  consumer accepts period when high together with period_valid.
- period  output  WIDTH  last measured interval.
- period_valid  output  1  period holds an unconsumed measurement.
- overrun  output  1  one-cycle pulse when an unconsumed measurement is overwritten.
- locked  output  1  interval stable.
- timeout  output  1  one-cycle pulse when no tick arrives in time; tied 0 when the optional feature is off.

Behaviour:
- Reset (rst=0, asynchronous): state=SEEK, cnt=0, ref=0, run=0. All outputs 0: period, period_valid, overrun, locked, timeout.
- Interval counter cnt:
  - Increments on each edge with en=1 and tick=0.
  - On an edge with tick=1, cnt is cleared to 0.
  - The measured value is cnt as sampled at that tick edge.
  - With en tied high and ticks from a counter of limit L, every measurement equals L.
- State SEEK: no reference tick yet. On tick: cnt<=0, go MEAS, no measurement output.
- State MEAS and state LOCKED, on each tick:
  - Capture m=cnt into period and set period_valid=1.
  - If period_valid was 1 and out_ready=0 on that edge, pulse overrun for one cycle. The new value overwrites the old one.
  - If m==ref: run<=run+1, saturating at LOCK_COUNT. Otherwise ref<=m and run<=1.
  - locked and state LOCKED are entered on the same edge that run reaches LOCK_COUNT.
  - A mismatch in LOCKED clears locked and returns to MEAS on that edge.
- The first measurement after SEEK sets ref=m and run=1. This holds even if m equals the stale ref.
- Handshake:
  - period_valid clears on an edge where period_valid=1, out_ready=1 and no tick occurs.
  - On an edge with tick=1 and out_ready=1 together, the old value is consumed and the new one loaded. period_valid stays 1 and there is no overrun.
  - period is stable while period_valid=1 and no tick occurs.
- Timeout/saturation: behaviour at cnt==2^WIDTH-1 with en=1 and tick=0 is defined under Optional Feature.
- Simultaneous events: tick takes priority over timeout and saturation on the same edge.
- Latency: period, period_valid and locked update on the same edge that samples tick. Visible one cycle after the tick cycle.
- A reset mid-measurement discards cnt and lock state; the next tick is treated as the reference.

Optional Feature:
- Macro: TICK_PERIOD_METER_TIMEOUT_EN.
- Defined: when cnt==2^WIDTH-1 and en=1 and tick=0:
  - pulse timeout for one cycle;
  - cnt<=0, run<=0, locked<=0, go SEEK;
  - period and period_valid are untouched.
- Not defined:
  - cnt saturates at 2^WIDTH-1 and the next tick reports 2^WIDTH-1;
  - lock logic runs normally;
  - timeout is constant 0.

Test Plan:
- en=1, out_ready=1, ticks every 6 cycles (counter limit 5) → first tick no output. Each later tick gives period=5 with a one-cycle period_valid. locked=1 on the edge of the 3rd period=5 measurement.
- Locked at 5, then one interval of 8 cycles (period=7) → period=7, locked falls on that edge, run=1. Three further intervals of 7 → locked reasserts.
- en toggled 1,0 alternately, tick gap of 10 cycles → period=5 (only the en=1 non-tick cycles are counted).
- out_ready=0, two measurements 5 then 5 → overrun pulses on the second, period=5, period_valid stays 1. Raise out_ready with no tick → period_valid=0 next edge.
- Tick and out_ready=1 on the same edge while period_valid=1 → new value loaded, period_valid stays 1, overrun=0.
- Timeout, with the macro defined: WIDTH=4, en=1, no tick for 16 cycles after the reference → timeout pulses once, locked=0, state SEEK; the next tick yields no output. Without the macro: the next tick reports period=15. Also assert rst=0 mid-interval → all outputs 0 immediately.

Source files
------------

// File: rtl/tick_period_meter.sv
// Purpose : measures the spacing of a single-cycle tick stream and flags lock
//           once LOCK_COUNT consecutive measurements agree.
// Latency : period/period_valid/locked update on the edge that samples tick.
// Backpressure: period holds until consumed; a tick with an unconsumed value
//           and out_ready=0 overwrites it and pulses overrun.
//
// Ports:
//   clk, rst (async active-low) ; en qualifies counted cycles ; tick is the
//   pulse to measure ; out_ready/period/period_valid form the result handshake ;
//   overrun, locked, timeout are status outputs.
// Optional feature macro: TICK_PERIOD_METER_TIMEOUT_EN -- when defined, an
//   interval counter reaching 2^WIDTH-1 pulses timeout and drops back to SEEK;
//   otherwise the counter saturates and timeout is constant 0.
module tick_period_meter #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             out_ready,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overrun,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {SEEK, MEAS, LOCKED} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_val_q, ref_val_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       run_next;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_val_d = ref_val_q;
    run_d     = run_q;
    run_next  = run_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    // Consumption; a tick on the same edge reloads valid below.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      cnt_d = '0;
      if (state_q == SEEK) begin
        // Reference tick only: nothing has been measured yet.
        state_d = MEAS;
      end else begin
        period_d  = cnt_q;
        valid_d   = 1'b1;
        overrun_d = valid_q && !out_ready;
        // run_q==0 marks the first measurement after SEEK, which always
        // restarts the run even if it happens to equal the stale reference.
        if ((run_q != 4'd0) && (cnt_q == ref_val_q)) begin
          run_next = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + 4'd1;
        end else begin
          ref_val_d = cnt_q;
          run_next  = 4'd1;
        end
        run_d = run_next;
        if (run_next == LOCK_RUN) begin
          locked_d = 1'b1;
          state_d  = LOCKED;
        end else begin
          locked_d = 1'b0;
          state_d  = MEAS;
        end
      end
    end else if (en && (state_q != SEEK)) begin
      // The counter is held at 0 while seeking: the reference tick clears it
      // anyway, and this keeps a tick-less line from re-firing timeout.
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
`ifdef TICK_PERIOD_METER_TIMEOUT_EN
        timeout_d = 1'b1;
        cnt_d     = '0;
        run_d     = 4'd0;
        locked_d  = 1'b0;
        state_d   = SEEK;
`else
        cnt_d = cnt_q;  // saturate; the next tick reports the maximum
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SEEK;
      cnt_q     <= '0;
      ref_val_q <= '0;
      run_q     <= 4'd0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_val_q <= ref_val_d;
      run_q     <= run_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
module tb_tick_period_meter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         tick = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         overrun;
  logic         locked;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  int tmo_seen = 0;
  logic [W-1:0] exp_q[$];

  tick_period_meter #(.WIDTH(W), .LOCK_COUNT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .out_ready(out_ready),
    .period(period), .period_valid(period_valid), .overrun(overrun),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: inputs change at negedge, outputs sampled 1 time unit after posedge.
  task automatic drive(input logic t, input logic e, input logic r);
    @(negedge clk);
    tick = t; en = e; out_ready = r;
    @(posedge clk);
    #1;
    if (timeout === 1'b1) tmo_seen++;
  endtask

  // n idle cycles; alt=1 toggles en 1,0,1,... starting at 1.
  task automatic gap(input int n, input logic alt, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, alt ? ((i % 2) == 0) : 1'b1, r);
  endtask

  // Tick that must produce a measurement: expectation queued, popped on output.
  task automatic meas(input string tag, input logic [W-1:0] expv, input logic r);
    logic [W-1:0] e;
    exp_q.push_back(expv);
    drive(1'b1, 1'b1, r);
    chk({tag, "_valid"}, period_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_period"}, period, e);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b1;

    // Steady interval of 5 with free-flowing consumer
    drive(1'b1, 1'b1, 1'b1);
    chk("ref_no_output", period_valid, 0);
    gap(5, 0, 1);
    meas("p5a", 5, 1);
    chk("p5a_locked", locked, 0);
    drive(1'b0, 1'b1, 1'b1);
    chk("p5a_valid_one_cycle", period_valid, 0);
    gap(4, 0, 1);
    meas("p5b", 5, 1);
    chk("p5b_locked", locked, 0);
    gap(5, 0, 1);
    meas("p5c", 5, 1);
    chk("p5c_locked", locked, 1);

    // Interval change to 7 breaks lock, then relock after three equal values
    gap(7, 0, 1);
    meas("p7a", 7, 1);
    chk("p7a_unlocked", locked, 0);
    gap(7, 0, 1);
    meas("p7b", 7, 1);
    chk("p7b_locked", locked, 0);
    gap(7, 0, 1);
    meas("p7c", 7, 1);
    chk("p7c_locked", locked, 1);
    gap(7, 0, 1);
    meas("p7d", 7, 1);
    chk("p7d_locked", locked, 1);

    // en alternating over a 10-cycle tick spacing counts 5 cycles
    gap(9, 1, 1);
    meas("en_alt", 5, 1);
    chk("en_alt_unlocked", locked, 0);

    // Backpressure: second measurement overwrites the first
    gap(1, 0, 1);
    gap(4, 0, 0);
    meas("bp1", 5, 0);
    chk("bp1_overrun", overrun, 0);
    gap(5, 0, 0);
    meas("bp2", 5, 0);
    chk("bp2_overrun", overrun, 1);
    chk("bp2_locked", locked, 1);
    drive(1'b0, 1'b1, 1'b0);
    chk("bp_overrun_pulse", overrun, 0);
    chk("bp_valid_held", period_valid, 1);
    chk("bp_period_held", period, 5);
    drive(1'b0, 1'b1, 1'b1);
    chk("bp_consumed", period_valid, 0);

    // Tick and out_ready together while valid: reload without overrun
    gap(3, 0, 0);
    meas("tr1", 5, 0);
    gap(6, 0, 0);
    meas("tr2", 6, 1);
    chk("tr2_overrun", overrun, 0);
    chk("tr2_unlocked", locked, 0);

    // Long gap: saturation (default) or timeout (feature enabled)
    drive(1'b0, 1'b1, 1'b1);
    tmo_seen = 0;
    gap(19, 0, 1);
`ifdef TICK_PERIOD_METER_TIMEOUT_EN
    chk("tmo_pulses", tmo_seen, 1);
    chk("tmo_locked", locked, 0);
    drive(1'b1, 1'b1, 1'b1);
    chk("tmo_next_tick_no_output", period_valid, 0);
`else
    chk("sat_no_timeout", tmo_seen, 0);
    meas("sat", 15, 1);
`endif

    // Build lock with pending data, then reset mid-interval
    drive(1'b1, 1'b1, 1'b1);
    gap(4, 0, 0);
    meas("pre_rst_a", 4, 0);
    gap(4, 0, 0);
    meas("pre_rst_b", 4, 0);
    gap(4, 0, 0);
    meas("pre_rst_c", 4, 0);
    chk("pre_rst_locked", locked, 1);
    gap(2, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_valid", period_valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    chk("post_rst_ref", period_valid, 0);
    gap(3, 0, 1);
    meas("post_rst", 3, 1);
    chk("post_rst_unlocked", locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
